guess_display: RTL
==================

Name: guess_display

Overview:
- Output-side counterpart of the keypad entry path: the keypad path turns decimal key presses into a binary guess; this block turns a binary value back into decimal digits and drives a 4-digit multiplexed 7-segment display.
- Digits 2..0 show the hundreds, tens and ones of the loaded value.
- Digit 3 shows a status letter derived from the comparator and control flags.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock.

Parameters:
SCAN_DIV, 1024, clock cycles each digit stays enabled before the scan advances (minimum 2).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
load  input  1  one-cycle strobe: start converting value
value  input  8  unsigned binary value to display, 0..255
lt  input  1  guess below target
gt  input  1  guess above target
done  input  1  game won
outrange  input  1  guess outside current limits
busy  output  1  conversion in progress
seg  output  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a
an  output  4  active-low digit enables, an[0] = ones digit

Behaviour:
- Reset, when rst is high at an edge:
  - FSM goes to IDLE and busy=0.
  - Hundreds, tens and ones digit registers are set to 0.
  - Scan counter and digit index are set to 0.
  - an=4'b1111 and seg=7'b1111111.
  - Reset aborts any conversion in progress. Display digits stay 0.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: when load=1 at edge k, capture value into the shift register, clear the BCD accumulator, set the bit counter to 0 and go to CONV.
  - CONV: each edge, add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1. After 8 shifts (edges k+1..k+8) go to COMMIT.
  - COMMIT: at edge k+9, copy the BCD nibbles into the display digit registers and return to IDLE.
- busy=1 while in CONV or COMMIT. It is high after edge k and low after edge k+9.
- load while busy=1 is ignored and not queued. load in the same cycle that COMMIT finishes is ignored.
- Display digit registers change only in COMMIT. The previous value stays displayed during conversion.
- Scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - seg and an are registered from the current index and digit registers, so they lag the index by one clock.
  - an = ~(4'b0001 << idx).
- Digit encodings, active-low gfedcba:
  - Numbers: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Status digit (idx 3) is sampled live each cycle. Priority: outrange '-'=0111111 > done 'd'=0100001 > gt 'H'=0001001 > lt 'L'=1000111 > blank=1111111.
- Digit values are always 0..9 by construction. Any other nibble displays blank.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - The hundreds digit shows blank (1111111) when it is 0.
  - The tens digit shows blank when both hundreds and tens are 0.
  - The ones digit is always shown.
- Undefined: all three numeric digits are always shown, including leading zeros.
- Either way, blanking affects only seg. It does not affect an timing or the digit registers.

Test Plan (SCAN_DIV=4):
- Reset: rst high 2 cycles then low → an=1111 and seg=1111111 during reset. One clock after release, an=1110 and seg=1000000 (ones digit is 0). After 4 more cycles an=1101.
- load=1 with value=57 for 1 cycle → busy=1 for exactly 9 cycles, then digits are 0/5/7. Observed patterns: ones an=1110 seg=1111000, tens an=1101 seg=0010010, hundreds seg=1000000 (feature off).
- value=255, then value=0 → digits 2/5/5 (0100100, 0010010, 0010010), then 0/0/0. With LEADING_ZERO_BLANK_EN and value=7: hundreds=1111111, tens=1111111, ones=1111000.
- load 57, then load 99 pulsed 3 cycles later → 99 ignored, display ends at 57. A second load of 99 after busy falls → display shows 99 ten cycles later.
- Status flags:
  - gt=1 → digit 3 (an=0111) seg=0001001.
  - gt=1 and outrange=1 → seg=0111111.
  - done=1 and lt=1 → seg=0100001.
  - All flags 0 → seg=1111111.
- Display 57, then load 123 and assert rst at the 4th CONV cycle → busy=0 the next cycle, digits 0/0/0, and no COMMIT of 123 ever occurs.

Source files
------------

// File: rtl/guess_display.sv
// Binary-to-BCD (double dabble, one bit per clock) feeding a 4-digit multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module guess_display #(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       lt,
    input  logic       gt,
    input  logic       done,
    input  logic       outrange,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t         state, state_nx;
    logic [7:0]     bin;
    logic [11:0]    bcd;
    logic [11:0]    bcd_adj;
    logic [2:0]     bitcnt;
    logic [3:0]     dig_h, dig_t, dig_o;
    logic [CW-1:0]  scan_cnt;
    logic [1:0]     idx;
    logic [6:0]     seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = CONV;
            CONV:    if (bitcnt == 3'd7) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin    <= '0;
            bcd    <= '0;
            bitcnt <= '0;
            dig_h  <= '0;
            dig_t  <= '0;
            dig_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin    <= value;
                        bcd    <= '0;
                        bitcnt <= '0;
                    end
                end
                CONV: begin
                    // bcd_adj[11] can never be set for an 8-bit input, so dropping it is safe
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    bitcnt     <= bitcnt + 3'd1;
                end
                COMMIT: begin
                    dig_h <= bcd[11:8];
                    dig_t <= bcd[7:4];
                    dig_o <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seg_nx = 7'b1111111;
        case (idx)
            2'd0: seg_nx = seg7(dig_o);
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (dig_h == 4'd0 && dig_t == 4'd0) seg_nx = 7'b1111111;
                else                                seg_nx = seg7(dig_t);
`else
                seg_nx = seg7(dig_t);
`endif
            end
            2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (dig_h == 4'd0) seg_nx = 7'b1111111;
                else               seg_nx = seg7(dig_h);
`else
                seg_nx = seg7(dig_h);
`endif
            end
            2'd3: begin
                if (outrange)  seg_nx = 7'b0111111;
                else if (done) seg_nx = 7'b0100001;
                else if (gt)   seg_nx = 7'b0001001;
                else if (lt)   seg_nx = 7'b1000111;
                else           seg_nx = 7'b1111111;
            end
            default: seg_nx = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= '1;
            an       <= '1;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_nx;
        end
    end

endmodule
